// File: rtl/delay_line_ctrl.sv
// Valid/ready controller for an external enable-driven delay line.
// Tags mirror the line; end-of-line triggers Depth zero-pad shifts.
module delay_line_ctrl #(
  parameter int Width = 16,
  parameter int Depth = 4,
  parameter int CntW  = $clog2(Depth + 1)
) (
  input  logic             clk_i,
  input  logic             rst_n_i,
  input  logic             s_valid_i,
  output logic             s_ready_o,
  input  logic             s_last_i,
  input  logic [Width-1:0] s_data_i,
  output logic             sr_en_o,
  output logic [Width-1:0] sr_din_o,
  input  logic [Width-1:0] sr_dout_i,
  output logic             m_valid_o,
  input  logic             m_ready_i,
  output logic             m_last_o,
  output logic [Width-1:0] m_data_o,
  output logic             busy_o
);

  typedef enum logic {
    RUN   = 1'b0,
    FLUSH = 1'b1
  } state_t;

  state_t          r_state;
  state_t          w_state_nxt;
  logic [CntW-1:0] r_cnt;
  logic [CntW-1:0] w_cnt_nxt;
  logic [Depth-1:0] r_vbit;
  logic [Depth-1:0] r_lbit;
  logic [Depth:0]  w_vsh;
  logic [Depth:0]  w_lsh;
  logic            w_head_ok;
  logic            w_shift;
  logic            w_in_v;
  logic            w_in_l;

  // Extra low bit lets the shift work for Depth=1 too.
  assign w_vsh = {r_vbit, w_in_v};
  assign w_lsh = {r_lbit, w_in_l};

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      r_state <= RUN;
      r_cnt   <= '0;
      r_vbit  <= '0;
      r_lbit  <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      if (w_shift) begin
        r_vbit <= w_vsh[Depth-1:0];
        r_lbit <= w_lsh[Depth-1:0];
      end
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_head_ok   = !r_vbit[Depth-1] | m_ready_i;
    w_shift     = 1'b0;
    w_in_v      = 1'b0;
    w_in_l      = 1'b0;
    s_ready_o   = 1'b0;
    sr_din_o    = '0;
    m_valid_o   = 1'b0;
    unique case (r_state)
      RUN: begin
        s_ready_o = w_head_ok;
        w_shift   = s_valid_i & w_head_ok;
        w_in_v    = 1'b1;
        w_in_l    = s_last_i;
        sr_din_o  = s_data_i;
        m_valid_o = r_vbit[Depth-1] & s_valid_i;
        if (w_shift && s_last_i) begin
          w_state_nxt = FLUSH;
          w_cnt_nxt   = '0;
        end
      end
      FLUSH: begin
        w_shift   = w_head_ok;
        m_valid_o = r_vbit[Depth-1];
        if (w_shift) begin
          if (r_cnt == CntW'(Depth - 1)) begin
            w_state_nxt = RUN;
            w_cnt_nxt   = '0;
          end else begin
            w_cnt_nxt = r_cnt + 1'b1;
          end
        end
      end
      default: ;
    endcase
  end

  assign sr_en_o  = w_shift;
  assign m_last_o = r_lbit[Depth-1] & m_valid_o;
  assign m_data_o = sr_dout_i;
  assign busy_o   = (r_state == FLUSH);

endmodule
